// File: rtl/mem_bist_pkg.sv
// Shared types and default widths for the memory BIST sequencer.
package mem_bist_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ERR_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_CLEAR,
    PH_DATA_ADDR
  } phase_e;

endpackage

// File: rtl/mem_bist_checker.sv
// Expected-word generation, one-deep read compare pipeline and saturating error count.
// MEM_BIST_FAIL_LOG_EN adds capture of the first failing address and read data.
module mem_bist_checker
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ERR_WIDTH  = DEF_ERR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  phase_e                phase_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [ERR_WIDTH-1:0]  err_count_o
`ifdef MEM_BIST_FAIL_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o
`endif
);

  // Zero-extends or truncates the address to a data word, depending on widths.
  function automatic logic [DATA_WIDTH-1:0] expected_word(phase_e ph, logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] wide;
    wide = {{DATA_WIDTH{1'b0}}, a};
    return (ph == PH_DATA_ADDR) ? wide[DATA_WIDTH-1:0] : '0;
  endfunction

  logic                  cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  phase_e                cmp_phase_q, cmp_phase_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  mismatch;

  assign wdata_o     = expected_word(phase_i, addr_i);
  assign err_count_o = err_q;

  always_comb begin
    cmp_vld_d   = rd_i & ~clear_i;
    cmp_addr_d  = addr_i;
    cmp_phase_d = phase_i;
    mismatch    = cmp_vld_q && (rdata_i != expected_word(cmp_phase_q, cmp_addr_q));
    err_d       = err_q;
    if (clear_i) begin
      err_d = '0;
    end else if (mismatch && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_phase_q <= PH_CLEAR;
      err_q       <= '0;
    end else begin
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_phase_q <= cmp_phase_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  // err_q is still zero only on the first mismatch of a run.
  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clear_i) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (mismatch && (err_q == '0)) begin
      fail_addr_d = cmp_addr_q;
      fail_data_d = rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer: Clear test then Data=Address test over a synchronous memory.
// MEM_BIST_FAIL_LOG_EN adds fail_addr/fail_data outputs for the first mismatch.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ERR_WIDTH  = DEF_ERR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_read,
  output logic                  mem_write
`ifdef MEM_BIST_FAIL_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
`endif
);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic                  start_acc;
  logic                  last_addr;
  logic [DATA_WIDTH-1:0] wdata;

  assign last_addr = (addr_q == {ADDR_WIDTH{1'b1}});

  // Address rolls over to zero naturally after the last location of a sweep.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          pass_d    = 1'b0;
          phase_d   = PH_CLEAR;
          addr_d    = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (last_addr) state_d = ST_READ;
      end
      ST_READ: begin
        addr_d = addr_q + 1'b1;
        if (last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (phase_q == PH_CLEAR) begin
          phase_d = PH_DATA_ADDR;
          addr_d  = '0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pass_d  = (err_count == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_CLEAR;
      addr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end

  assign mem_write   = (state_q == ST_WRITE);
  assign mem_read    = (state_q == ST_READ);
  assign mem_addr    = addr_q;
  assign mem_data_in = mem_write ? wdata : '0;
  assign busy        = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;

  mem_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_checker (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (start_acc),
    .phase_i     (phase_q),
    .addr_i      (addr_q),
    .rd_i        (mem_read),
    .rdata_i     (mem_data_out),
    .wdata_o     (wdata),
    .err_count_o (err_count)
`ifdef MEM_BIST_FAIL_LOG_EN
    ,
    .fail_addr_o (fail_addr),
    .fail_data_o (fail_data)
`endif
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl with behavioural faulty-memory models.
// MEM_BIST_FAIL_LOG_EN enables checking of the fail_addr/fail_data capture.
module tb_mem_bist_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int EW  = 8;
  localparam int EW4 = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_read, mem_write;

  logic           start4;
  logic           busy4, done4, pass4;
  logic [EW4-1:0] err_count4;
  logic [AW-1:0]  mem_addr4;
  logic [DW-1:0]  mem_data_in4, mem_data_out4;
  logic           mem_read4, mem_write4;

`ifdef MEM_BIST_FAIL_LOG_EN
  logic [AW-1:0] fail_addr, fail_addr4;
  logic [DW-1:0] fail_data, fail_data4;
`endif

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;

  logic [DW-1:0]    mem [2**AW];
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [EW:0]      exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_read     (mem_read),
    .mem_write    (mem_write)
`ifdef MEM_BIST_FAIL_LOG_EN
    ,
    .fail_addr    (fail_addr),
    .fail_data    (fail_data)
`endif
  );

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
    .busy         (busy4),
    .done         (done4),
    .pass         (pass4),
    .err_count    (err_count4),
    .mem_addr     (mem_addr4),
    .mem_data_in  (mem_data_in4),
    .mem_data_out (mem_data_out4),
    .mem_read     (mem_read4),
    .mem_write    (mem_write4)
`ifdef MEM_BIST_FAIL_LOG_EN
    ,
    .fail_addr    (fail_addr4),
    .fail_data    (fail_data4)
`endif
  );

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] rd_model(input int fault, input logic [AW-1:0] a,
                                             input logic [DW-1:0] stored);
    case (fault)
      1:       return (a == AW'(5)) ? (stored | 8'h08) : stored;
      2:       return 8'hFF;
      default: return stored;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out  <= rd_model(fault_mode, mem_addr, mem[mem_addr]);
    if (mem_read4) mem_data_out4 <= rd_model(2, mem_addr4, 8'h00);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("rw_excl", {31'd0, mem_read && mem_write}, 0);
      if (!mem_write) check("din_idle", {24'd0, mem_data_in}, 0);
      check("rw_excl4", {31'd0, mem_read4 && mem_write4}, 0);
      if (!mem_write4) check("din_idle4", {24'd0, mem_data_in4}, 0);
    end
  end

  // Reference: walk both phases, predict what each read returns, count mismatches.
  task automatic model(input int fault, output int e_clear, output int e_total,
                       output int f_addr, output int f_data);
    logic [DW-1:0] expv, rdv;
    e_clear = 0; e_total = 0; f_addr = 0; f_data = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 2**AW; a++) begin
        expv = (ph == 1) ? DW'(a) : '0;
        rdv  = rd_model(fault, AW'(a), expv);
        if (rdv != expv) begin
          if (e_total == 0) begin f_addr = a; f_data = int'(rdv); end
          e_total++;
          if (ph == 0) e_clear++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_test(input int fault, input bit repulse);
    int e_clear, e_total, f_addr, f_data, exp_err, n, done_n, n_wr, n_rd;
    logic [AW+DW-1:0] wr_e;
    logic [EW:0]      res_e;
    logic [DW-1:0]    dv;
    model(fault, e_clear, e_total, f_addr, f_data);
    exp_err    = (e_total > 2**EW - 1) ? 2**EW - 1 : e_total;
    fault_mode = fault;
    @(negedge clk);
    start = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 2**AW; a++) begin
        dv = (ph == 1) ? DW'(a) : '0;
        wr_q.push_back({AW'(a), dv});
        rd_q.push_back(AW'(a));
      end
    end
    exp_q.push_back({EW'(exp_err), exp_err == 0});
    @(negedge clk);
    start = 1'b0;
    n = 1; done_n = 0; n_wr = 0; n_rd = 0;
    check("pass_clr", {31'd0, pass}, 0);
    check("err_clr", {24'd0, err_count}, 0);
    while (n <= 200 && done_n == 0) begin
      if (mem_write) begin
        n_wr++;
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          wr_e = wr_q.pop_front();
          check("wr_beat", {19'd0, mem_addr, mem_data_in}, {19'd0, wr_e});
        end
      end
      if (mem_read) begin
        n_rd++;
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", {27'd0, mem_addr}, {27'd0, rd_q.pop_front()});
      end
      check("busy", {31'd0, busy}, {31'd0, n <= 130});
      if (done) done_n = n;
      if (repulse) begin
        if (n == 10) start = 1'b1;
        if (n == 11) start = 1'b0;
        if (n == 71) check("err_hold", {24'd0, err_count}, e_clear);
        if (done) start = 1'b1;
      end
      if (done_n == 0) begin
        @(negedge clk);
        n++;
      end
    end
    if (done_n == 0) check("done_timeout", 0, 1);
    check("done_cycle", done_n, 131);
    check("n_writes", n_wr, 64);
    check("n_reads", n_rd, 64);
    @(negedge clk);
    start = 1'b0;
    if (exp_q.size() == 0) check("res_missing", 1, 0);
    else begin
      res_e = exp_q.pop_front();
      check("err_count", {24'd0, err_count}, {24'd0, res_e[EW:1]});
      check("pass", {31'd0, pass}, {31'd0, res_e[0]});
    end
    check("done_pulse", {31'd0, done}, 0);
`ifdef MEM_BIST_FAIL_LOG_EN
    check("fail_addr", {27'd0, fail_addr}, f_addr);
    check("fail_data", {24'd0, fail_data}, f_data);
`endif
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_write", {31'd0, mem_write}, 0);
    end
    wr_q.delete();
    rd_q.delete();
    exp_q.delete();
  endtask

  task automatic run_sat();
    int n, e_clear, e_total, fa, fd, exp4;
    model(2, e_clear, e_total, fa, fd);
    exp4 = (e_total > 2**EW4 - 1) ? 2**EW4 - 1 : e_total;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (n <= 200 && !done4) begin
      @(negedge clk);
      n++;
    end
    check("sat_done_cycle", n, 131);
    @(negedge clk);
    check("sat_err", {28'd0, err_count4}, exp4);
    check("sat_pass", {31'd0, pass4}, 0);
  endtask

  task automatic run_reset();
    int n;
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_err", {24'd0, err_count}, 0);
    check("rst_addr", {27'd0, mem_addr}, 0);
    check("rst_din", {24'd0, mem_data_in}, 0);
    check("rst_read", {31'd0, mem_read}, 0);
    check("rst_write", {31'd0, mem_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("init_busy", {31'd0, busy}, 0);
    check("init_done", {31'd0, done}, 0);
    check("init_pass", {31'd0, pass}, 0);
    check("init_err", {24'd0, err_count}, 0);
    check("init_addr", {27'd0, mem_addr}, 0);
    check("init_strobes", {30'd0, mem_read, mem_write}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(0, 1'b0);
    run_test(1, 1'b0);
    run_test(2, 1'b0);
    run_sat();
    run_reset();
    run_test(0, 1'b0);
    run_test(1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
